iencoder: RTL and testbench
===========================

Name: iencoder

Overview:
- Inverse of the instruction decoder: converts decoded fields (inst_type, funct, rd, rs1, rs2, imm) back into a 32-bit RV32I instruction word.
- Intended uses:
  - the debug/instruction-injection path;
  - self-checking round-trip benches (encoder -> decoder).
- Streaming block with valid/ready on both sides.
- Includes a registered encode stage and a small output FIFO so it tolerates downstream backpressure.

Parameters:
- FIFO_DEPTH, 2, number of output buffer entries; power of two, >= 2.
- CNT_WIDTH, 16, width of the encoded-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  decoded-field packet valid.
- in_ready  out  1  encoder can accept a packet this cycle.
- inst_type  in  `INST_TYPE_WIDTH  `INST_TYPE_* code.
- funct  in  `FUNCT_WIDTH  `FUNCT_* code; ignored for LUI/JAL/JALR/AUIPC/FENCE.
- rd  in  `REG_WIDTH  destination register.
- rs1  in  `REG_WIDTH  source register 1.
- rs2  in  `REG_WIDTH  source register 2.
- imm  in  `IMM_WIDTH  immediate in the same form the decoder produces.
- out_valid  out  1  encoded word available.
- out_ready  in  1  consumer accepts the word.
- out_inst  out  `INST_WIDTH  encoded instruction.
- out_err  out  1  packet was not encodable; out_inst = 32'h0000_0013 (NOP).
- enc_count  out  CNT_WIDTH  number of words popped from the output; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (rst low, asynchronous): FIFO empty, encode stage empty, out_valid=0, out_inst=0, out_err=0, enc_count=0.
- Handshake:
  - A transfer occurs when valid && ready on the rising edge.
  - in_ready = !(stage_full && fifo_full).
  - The encode stage advances into the FIFO whenever the FIFO is not full.
- Latency: a packet accepted in cycle N appears at out_valid in cycle N+1 if the FIFO was empty; it is registered through the stage, and the FIFO head is a bypass when empty.
- Throughput: 1 word per cycle while out_ready=1.
- Opcodes and fixed fields, per inst_type:
  - IMM: LUI 0110111, imm[31:12].
  - AUIPC: 0010111.
  - JAL: 1101111, J-imm scrambled from imm[20:1].
  - JALR: 1100111, I-type, funct3=0.
  - INT_IMM: 0010011, I-type.
    - Shifts (SLL/SRL/SRA) place imm[4:0] in bits 24:20.
    - funct7 = 0100000 for SRA, otherwise 0.
  - INT_REG: 0110011, R-type; funct7 = 0100000 for SUB/SRA.
  - BRANCH: 1100011, B-imm from imm[12:1]; EQ=0, NEQ=1, LT=4, GTE=5, LTU=6, GTEU=7.
  - STORE: 0100011, S-type; BYTE=0, HWORD=1, WORD=2.
  - LOAD: 0000011; BYTE=0, HWORD=1, WORD=2, BYTEU=4, HWORDU=5.
  - FENCE: fixed 32'h0FF0_000F.
- Unused register fields are zero: rd for BRANCH/STORE, rs2 for I/U/J types.
- Error cases, all emitting out_err=1 with the NOP word in order (never dropped):
  - unknown inst_type;
  - funct not legal for the type (e.g. SUB under INT_IMM, MEM_BYTEU under STORE).
- Simultaneous push and pop when the FIFO is full: allowed; the count stays constant.
- FIFO pointers wrap modulo FIFO_DEPTH.
- enc_count increments on each out_valid && out_ready pop, including error words.
- Reset mid-stream discards all buffered words with no partial output.

Optional Feature:
- Macro: IENCODER_RANGE_CHECK_EN.
- Defined: imm must be representable, otherwise out_err=1 and NOP. Representable means:
  - sign-extension consistent above the field's MSB;
  - low bits zero for U (imm[11:0]), J/B (imm[0]);
  - shift amount imm[31:5] == 0.
- Undefined: out-of-range imm bits are silently truncated; out_err covers only type/funct errors.

Decomposition:
- `OPCODE_*, `INST_TYPE_*, `FUNCT_*, and the widths stay in the shared copperv_h.v header.
- Add to the same header: `FUNCT3_* and `FUNCT7_* encodings, and NOP/FENCE word constants.
- One natural sub-module, iencoder_fifo: parameterised synchronous FIFO with a first-word bypass.
- The encode logic stays in iencoder as a combinational always block feeding the stage register.

Test Plan:
- addi: inst_type=INT_IMM, funct=ADD, rd=1, rs1=0, imm=5 -> out_inst=32'h0050_0093, out_err=0, out_valid one cycle after acceptance.
- sub: INT_REG, SUB, rd=3, rs1=1, rs2=2 -> 32'h4020_81B3.
- srai: INT_IMM, SRA, rd=5, rs1=6, imm=3 -> 32'h4033_5293.
- beq: BRANCH, EQ, rs1=1, rs2=2, imm=32'hFFFF_FFFC -> 32'hFE20_8EE3.
- lui: IMM, rd=2, imm=32'h1234_5000 -> 32'h1234_5137.
- Backpressure and reset:
  - out_ready=0, push FIFO_DEPTH+1 packets -> in_ready=0 on the next cycle.
  - Release out_ready -> words emerge in order, enc_count=3.
  - Assert rst mid-drain -> out_valid=0 immediately, enc_count=0.
- Error path: inst_type=INT_IMM, funct=SUB -> out_inst=32'h0000_0013, out_err=1, enc_count still increments on pop.
- With IENCODER_RANGE_CHECK_EN: LUI with imm=32'h0000_0001 -> out_err=1.
- Without IENCODER_RANGE_CHECK_EN: the same LUI packet -> out_inst=32'h0000_0137, out_err=0.

Source files
------------

// File: rtl/iencoder_pkg.sv
// Shared encodings for the RV32I instruction encoder: field codes, opcodes, funct3/funct7 values and fixed words.
// Also holds the funct-to-funct3 lookups; each returns {legal, funct3}.
package iencoder_pkg;

  localparam int INST_TYPE_WIDTH = 4;
  localparam int FUNCT_WIDTH     = 5;
  localparam int REG_WIDTH       = 5;
  localparam int IMM_WIDTH       = 32;
  localparam int INST_WIDTH      = 32;

  localparam logic [3:0] INST_TYPE_IMM     = 4'd0;
  localparam logic [3:0] INST_TYPE_INT_IMM = 4'd1;
  localparam logic [3:0] INST_TYPE_INT_REG = 4'd2;
  localparam logic [3:0] INST_TYPE_BRANCH  = 4'd3;
  localparam logic [3:0] INST_TYPE_STORE   = 4'd4;
  localparam logic [3:0] INST_TYPE_LOAD    = 4'd5;
  localparam logic [3:0] INST_TYPE_JAL     = 4'd6;
  localparam logic [3:0] INST_TYPE_JALR    = 4'd7;
  localparam logic [3:0] INST_TYPE_AUIPC   = 4'd8;
  localparam logic [3:0] INST_TYPE_FENCE   = 4'd9;

  localparam logic [4:0] FUNCT_ADD        = 5'd0;
  localparam logic [4:0] FUNCT_SUB        = 5'd1;
  localparam logic [4:0] FUNCT_SLL        = 5'd2;
  localparam logic [4:0] FUNCT_SLT        = 5'd3;
  localparam logic [4:0] FUNCT_SLTU       = 5'd4;
  localparam logic [4:0] FUNCT_XOR        = 5'd5;
  localparam logic [4:0] FUNCT_SRL        = 5'd6;
  localparam logic [4:0] FUNCT_SRA        = 5'd7;
  localparam logic [4:0] FUNCT_OR         = 5'd8;
  localparam logic [4:0] FUNCT_AND        = 5'd9;
  localparam logic [4:0] FUNCT_EQ         = 5'd10;
  localparam logic [4:0] FUNCT_NEQ        = 5'd11;
  localparam logic [4:0] FUNCT_LT         = 5'd12;
  localparam logic [4:0] FUNCT_GTE        = 5'd13;
  localparam logic [4:0] FUNCT_LTU        = 5'd14;
  localparam logic [4:0] FUNCT_GTEU       = 5'd15;
  localparam logic [4:0] FUNCT_MEM_BYTE   = 5'd16;
  localparam logic [4:0] FUNCT_MEM_HWORD  = 5'd17;
  localparam logic [4:0] FUNCT_MEM_WORD   = 5'd18;
  localparam logic [4:0] FUNCT_MEM_BYTEU  = 5'd19;
  localparam logic [4:0] FUNCT_MEM_HWORDU = 5'd20;

  localparam logic [6:0] OPCODE_LUI     = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL     = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR    = 7'b1100111;
  localparam logic [6:0] OPCODE_INT_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_INT_REG = 7'b0110011;
  localparam logic [6:0] OPCODE_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPCODE_STORE   = 7'b0100011;
  localparam logic [6:0] OPCODE_LOAD    = 7'b0000011;

  localparam logic [2:0] FUNCT3_ADD_SUB = 3'd0;
  localparam logic [2:0] FUNCT3_SLL     = 3'd1;
  localparam logic [2:0] FUNCT3_SLT     = 3'd2;
  localparam logic [2:0] FUNCT3_SLTU    = 3'd3;
  localparam logic [2:0] FUNCT3_XOR     = 3'd4;
  localparam logic [2:0] FUNCT3_SRL_SRA = 3'd5;
  localparam logic [2:0] FUNCT3_OR      = 3'd6;
  localparam logic [2:0] FUNCT3_AND     = 3'd7;
  localparam logic [2:0] FUNCT3_JALR    = 3'd0;
  localparam logic [2:0] FUNCT3_BEQ     = 3'd0;
  localparam logic [2:0] FUNCT3_BNE     = 3'd1;
  localparam logic [2:0] FUNCT3_BLT     = 3'd4;
  localparam logic [2:0] FUNCT3_BGE     = 3'd5;
  localparam logic [2:0] FUNCT3_BLTU    = 3'd6;
  localparam logic [2:0] FUNCT3_BGEU    = 3'd7;
  localparam logic [2:0] FUNCT3_BYTE    = 3'd0;
  localparam logic [2:0] FUNCT3_HWORD   = 3'd1;
  localparam logic [2:0] FUNCT3_WORD    = 3'd2;
  localparam logic [2:0] FUNCT3_BYTEU   = 3'd4;
  localparam logic [2:0] FUNCT3_HWORDU  = 3'd5;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  localparam logic [31:0] NOP_WORD   = 32'h0000_0013;
  localparam logic [31:0] FENCE_WORD = 32'h0FF0_000F;

  typedef struct packed {
    logic        err;
    logic [31:0] inst;
  } enc_t;

  function automatic logic [3:0] alu_f3(input logic [4:0] f);
    case (f)
      FUNCT_ADD, FUNCT_SUB: return {1'b1, FUNCT3_ADD_SUB};
      FUNCT_SLL:            return {1'b1, FUNCT3_SLL};
      FUNCT_SLT:            return {1'b1, FUNCT3_SLT};
      FUNCT_SLTU:           return {1'b1, FUNCT3_SLTU};
      FUNCT_XOR:            return {1'b1, FUNCT3_XOR};
      FUNCT_SRL, FUNCT_SRA: return {1'b1, FUNCT3_SRL_SRA};
      FUNCT_OR:             return {1'b1, FUNCT3_OR};
      FUNCT_AND:            return {1'b1, FUNCT3_AND};
      default:              return 4'b0;
    endcase
  endfunction

  function automatic logic [3:0] br_f3(input logic [4:0] f);
    case (f)
      FUNCT_EQ:   return {1'b1, FUNCT3_BEQ};
      FUNCT_NEQ:  return {1'b1, FUNCT3_BNE};
      FUNCT_LT:   return {1'b1, FUNCT3_BLT};
      FUNCT_GTE:  return {1'b1, FUNCT3_BGE};
      FUNCT_LTU:  return {1'b1, FUNCT3_BLTU};
      FUNCT_GTEU: return {1'b1, FUNCT3_BGEU};
      default:    return 4'b0;
    endcase
  endfunction

  // Unsigned widths exist only for loads.
  function automatic logic [3:0] mem_f3(input logic [4:0] f, input logic is_load);
    case (f)
      FUNCT_MEM_BYTE:   return {1'b1, FUNCT3_BYTE};
      FUNCT_MEM_HWORD:  return {1'b1, FUNCT3_HWORD};
      FUNCT_MEM_WORD:   return {1'b1, FUNCT3_WORD};
      FUNCT_MEM_BYTEU:  return {is_load, FUNCT3_BYTEU};
      FUNCT_MEM_HWORDU: return {is_load, FUNCT3_HWORDU};
      default:          return 4'b0;
    endcase
  endfunction

  function automatic logic sext_ok(input logic [31:0] v, input int msb);
    logic [31:0] s;
    s = $signed(v) >>> msb;
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/iencoder_fifo.sv
// Synchronous FIFO with first-word bypass: when empty, the input appears on the output in the same cycle.
// Accepts a write while full if the head is popped in that cycle; pointers wrap modulo DEPTH.
module iencoder_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          empty, full, wr, rd;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign in_rdy  = !full || out_rdy;
  assign out_vld = !empty || in_vld;
  assign out_dat = empty ? in_dat : mem[rptr];

  // A word popped straight through the bypass is never stored.
  assign wr = in_vld && in_rdy && !(empty && out_rdy);
  assign rd = out_rdy && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= in_dat;
  end

endmodule

// File: rtl/iencoder.sv
// RV32I encoder: decoded fields -> registered encode stage -> bypass FIFO; one cycle to out_valid when drained.
// in_ready drops only when the stage is held by a full FIFO; IENCODER_RANGE_CHECK_EN flags unrepresentable imm.
module iencoder
  import iencoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INST_TYPE_WIDTH-1:0] inst_type,
  input  logic [FUNCT_WIDTH-1:0]     funct,
  input  logic [REG_WIDTH-1:0]       rd,
  input  logic [REG_WIDTH-1:0]       rs1,
  input  logic [REG_WIDTH-1:0]       rs2,
  input  logic [IMM_WIDTH-1:0]       imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INST_WIDTH-1:0]      out_inst,
  output logic                       out_err,
  output logic [CNT_WIDTH-1:0]       enc_count
);

  enc_t        enc_dat, stage_dat, fifo_dat;
  logic        stage_vld, fifo_in_rdy;
  logic        legal, imm_ok, is_shift;
  logic [2:0]  f3;
  logic [31:0] word;

  assign is_shift = (funct == FUNCT_SLL) || (funct == FUNCT_SRL) || (funct == FUNCT_SRA);

  always_comb begin
    legal = 1'b1;
    f3    = 3'b000;
    word  = NOP_WORD;
    case (inst_type)
      INST_TYPE_IMM:   word = {imm[31:12], rd, OPCODE_LUI};
      INST_TYPE_AUIPC: word = {imm[31:12], rd, OPCODE_AUIPC};
      INST_TYPE_JAL:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPCODE_JAL};
      INST_TYPE_JALR:  word = {imm[11:0], rs1, FUNCT3_JALR, rd, OPCODE_JALR};
      INST_TYPE_INT_IMM: begin
        {legal, f3} = alu_f3(funct);
        if (funct == FUNCT_SUB) legal = 1'b0;
        if (is_shift)
          word = {(funct == FUNCT_SRA) ? FUNCT7_ALT : FUNCT7_BASE, imm[4:0], rs1, f3, rd, OPCODE_INT_IMM};
        else
          word = {imm[11:0], rs1, f3, rd, OPCODE_INT_IMM};
      end
      INST_TYPE_INT_REG: begin
        {legal, f3} = alu_f3(funct);
        word = {(funct == FUNCT_SUB || funct == FUNCT_SRA) ? FUNCT7_ALT : FUNCT7_BASE,
                rs2, rs1, f3, rd, OPCODE_INT_REG};
      end
      INST_TYPE_BRANCH: begin
        {legal, f3} = br_f3(funct);
        word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPCODE_BRANCH};
      end
      INST_TYPE_STORE: begin
        {legal, f3} = mem_f3(funct, 1'b0);
        word = {imm[11:5], rs2, rs1, f3, imm[4:0], OPCODE_STORE};
      end
      INST_TYPE_LOAD: begin
        {legal, f3} = mem_f3(funct, 1'b1);
        word = {imm[11:0], rs1, f3, rd, OPCODE_LOAD};
      end
      INST_TYPE_FENCE: word = FENCE_WORD;
      default:         legal = 1'b0;
    endcase
    enc_dat.err  = !legal || !imm_ok;
    enc_dat.inst = enc_dat.err ? NOP_WORD : word;
  end

`ifdef IENCODER_RANGE_CHECK_EN
  always_comb begin
    imm_ok = 1'b1;
    case (inst_type)
      INST_TYPE_IMM, INST_TYPE_AUIPC: imm_ok = (imm[11:0] == 12'h000);
      INST_TYPE_JAL:     imm_ok = !imm[0] && sext_ok(imm, 20);
      INST_TYPE_BRANCH:  imm_ok = !imm[0] && sext_ok(imm, 12);
      INST_TYPE_INT_IMM: imm_ok = is_shift ? (imm[31:5] == 27'h0) : sext_ok(imm, 11);
      INST_TYPE_JALR, INST_TYPE_STORE, INST_TYPE_LOAD: imm_ok = sext_ok(imm, 11);
      default:           imm_ok = 1'b1;
    endcase
  end
`else
  assign imm_ok = 1'b1;
`endif

  assign in_ready = !(stage_vld && !fifo_in_rdy);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_vld <= 1'b0;
      stage_dat <= '0;
    end else if (in_valid && in_ready) begin
      stage_vld <= 1'b1;
      stage_dat <= enc_dat;
    end else if (fifo_in_rdy) begin
      stage_vld <= 1'b0;
    end
  end

  iencoder_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(enc_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (stage_vld),
    .in_rdy  (fifo_in_rdy),
    .in_dat  (stage_dat),
    .out_vld (out_valid),
    .out_rdy (out_ready),
    .out_dat (fifo_dat)
  );

  // Gate the data so a stale stage word never shows while idle.
  assign out_inst = out_valid ? fifo_dat.inst : '0;
  assign out_err  = out_valid && fifo_dat.err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        enc_count <= '0;
    else if (out_valid && out_ready) enc_count <= enc_count + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_iencoder.sv
// Bench for iencoder: directed vectors with literal expectations, plus a field-arithmetic model and scoreboard.
module tb_iencoder;
  import iencoder_pkg::*;

`ifdef IENCODER_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [3:0]  inst_type = '0;
  logic [4:0]  funct = '0, rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] imm = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_inst;
  logic        out_err;
  logic [15:0] enc_count;

  int          tests = 0, fails = 0;
  logic [32:0] exp_q[$];
  logic [15:0] model_cnt = '0;

  typedef struct {
    string       name;
    logic [3:0]  t;
    logic [4:0]  f, rd, rs1, rs2;
    logic [31:0] imm, inst;
    logic        err;
  } vec_t;
  vec_t vecs[$];

  iencoder #(.FIFO_DEPTH(2), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst_type(inst_type), .funct(funct), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_err(out_err),
    .enc_count(enc_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic int alu(input logic [4:0] f);
    case (f)
      FUNCT_ADD, FUNCT_SUB: return 0;
      FUNCT_SLL:  return 1;
      FUNCT_SLT:  return 2;
      FUNCT_SLTU: return 3;
      FUNCT_XOR:  return 4;
      FUNCT_SRL, FUNCT_SRA: return 5;
      FUNCT_OR:   return 6;
      FUNCT_AND:  return 7;
      default:    return -1;
    endcase
  endfunction

  function automatic int br(input logic [4:0] f);
    case (f)
      FUNCT_EQ: return 0;  FUNCT_NEQ: return 1;  FUNCT_LT: return 4;
      FUNCT_GTE: return 5; FUNCT_LTU: return 6;  FUNCT_GTEU: return 7;
      default: return -1;
    endcase
  endfunction

  function automatic int mem(input logic [4:0] f, input bit ld);
    case (f)
      FUNCT_MEM_BYTE: return 0; FUNCT_MEM_HWORD: return 1; FUNCT_MEM_WORD: return 2;
      FUNCT_MEM_BYTEU: return ld ? 4 : -1;
      FUNCT_MEM_HWORDU: return ld ? 5 : -1;
      default: return -1;
    endcase
  endfunction

  // Builds the word by adding shifted fields; returns {err, inst}.
  function automatic logic [32:0] model(input logic [3:0] t, input logic [4:0] f, rdv, r1, r2,
                                        input logic [31:0] im);
    logic [31:0] w, R, S1, S2, F3;
    int si, f3;
    bit bad;
    R = 32'(rdv) << 7; S1 = 32'(r1) << 15; S2 = 32'(r2) << 20;
    si = $signed(im); bad = 0; f3 = 0; w = 0;
    case (t)
      INST_TYPE_IMM, INST_TYPE_AUIPC: begin
        w = (im & 32'hFFFF_F000) | R | ((t == INST_TYPE_IMM) ? 32'h37 : 32'h17);
        bad = RC && ((im & 32'hFFF) != 0);
      end
      INST_TYPE_JAL: begin
        w = (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21) | (((im >> 11) & 1) << 20)
          | (im & 32'h000F_F000) | R | 32'h6F;
        bad = RC && (im[0] || si < -1048576 || si > 1048575);
      end
      INST_TYPE_JALR: begin
        w = ((im & 32'hFFF) << 20) | S1 | R | 32'h67;
        bad = RC && (si < -2048 || si > 2047);
      end
      INST_TYPE_INT_IMM: begin
        f3 = (f == FUNCT_SUB) ? -1 : alu(f);
        if (f == FUNCT_SLL || f == FUNCT_SRL || f == FUNCT_SRA) begin
          w = ((f == FUNCT_SRA) ? 32'h4000_0000 : 0) | ((im & 31) << 20);
          bad = RC && (im > 31);
        end else begin
          w = (im & 32'hFFF) << 20;
          bad = RC && (si < -2048 || si > 2047);
        end
        w = w | S1 | R | 32'h13;
      end
      INST_TYPE_INT_REG: begin
        f3 = alu(f);
        w = ((f == FUNCT_SUB || f == FUNCT_SRA) ? 32'h4000_0000 : 0) | S2 | S1 | R | 32'h33;
      end
      INST_TYPE_BRANCH: begin
        f3 = br(f);
        w = (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25) | S2 | S1
          | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 1) << 7) | 32'h63;
        bad = RC && (im[0] || si < -4096 || si > 4095);
      end
      INST_TYPE_STORE: begin
        f3 = mem(f, 0);
        w = (((im >> 5) & 32'h7F) << 25) | S2 | S1 | ((im & 31) << 7) | 32'h23;
        bad = RC && (si < -2048 || si > 2047);
      end
      INST_TYPE_LOAD: begin
        f3 = mem(f, 1);
        w = ((im & 32'hFFF) << 20) | S1 | R | 32'h03;
        bad = RC && (si < -2048 || si > 2047);
      end
      INST_TYPE_FENCE: w = 32'h0FF0_000F;
      default: bad = 1;
    endcase
    if (f3 < 0) bad = 1;
    F3 = 32'(f3 & 7) << 12;
    if (t != INST_TYPE_FENCE && t != INST_TYPE_JALR && t != INST_TYPE_JAL
        && t != INST_TYPE_IMM && t != INST_TYPE_AUIPC) w = w | F3;
    return bad ? {1'b1, 32'h0000_0013} : {1'b0, w};
  endfunction

  task automatic add(input string n, input logic [3:0] t, input logic [4:0] f, rdv, r1, r2,
                     input logic [31:0] im, input logic [31:0] inst, input logic err);
    vec_t v;
    v.name = n; v.t = t; v.f = f; v.rd = rdv; v.rs1 = r1; v.rs2 = r2;
    v.imm = im; v.inst = inst; v.err = err;
    vecs.push_back(v);
  endtask

  // Presents one packet and holds it until accepted; the accepted word joins the scoreboard.
  task automatic send(input vec_t v);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; inst_type = v.t; funct = v.f; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm;
    #4;
    while (!in_ready && n < 50) begin
      @(negedge clk); #4; n++;
    end
    if (!in_ready) check({"accept_timeout_", v.name}, 0, 1);
    else exp_q.push_back(model(v.t, v.f, v.rd, v.rs1, v.rs2, v.imm));
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    #4;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk); #4;
      if (!out_valid) done = 1;
    end
    if (!done) check("drain_timeout", 0, 1);
  endtask

  // Scoreboard: sampled just before each rising edge, when every input and output is settled.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk); #4;
      if (rst) begin
        check("enc_count", enc_count, model_cnt);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("unexpected_word", out_inst, 0);
          else begin
            e = exp_q.pop_front();
            check("sb_inst", out_inst, e[31:0]);
            check("sb_err", out_err, e[32]);
          end
          model_cnt++;
        end
      end
    end
  end

  initial begin
    #200000;
    check("watchdog", 0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    add("addi",  INST_TYPE_INT_IMM, FUNCT_ADD, 1, 0, 0, 32'd5,         32'h0050_0093, 0);
    add("sub",   INST_TYPE_INT_REG, FUNCT_SUB, 3, 1, 2, 32'd0,         32'h4020_81B3, 0);
    add("srai",  INST_TYPE_INT_IMM, FUNCT_SRA, 5, 6, 0, 32'd3,         32'h4033_5293, 0);
    add("beq",   INST_TYPE_BRANCH,  FUNCT_EQ,  0, 1, 2, 32'hFFFF_FFFC, 32'hFE20_8EE3, 0);
    add("lui",   INST_TYPE_IMM,     FUNCT_ADD, 2, 0, 0, 32'h1234_5000, 32'h1234_5137, 0);
    add("jal",   INST_TYPE_JAL,     FUNCT_ADD, 1, 0, 0, 32'd8,         32'h0080_00EF, 0);
    add("sw",    INST_TYPE_STORE,   FUNCT_MEM_WORD, 0, 2, 5, 32'd12,   32'h0051_2623, 0);
    add("lw",    INST_TYPE_LOAD,    FUNCT_MEM_WORD, 5, 2, 0, 32'hFFFF_FFFC, 32'hFFC1_2283, 0);
    add("lbu",   INST_TYPE_LOAD,    FUNCT_MEM_BYTEU, 1, 2, 0, 32'd0,   32'h0001_4083, 0);
    add("slli",  INST_TYPE_INT_IMM, FUNCT_SLL, 1, 1, 0, 32'd31,        32'h01F0_9093, 0);
    add("bne",   INST_TYPE_BRANCH,  FUNCT_NEQ, 0, 3, 0, 32'd16,        32'h0001_9863, 0);
    add("fence", INST_TYPE_FENCE,   FUNCT_ADD, 0, 0, 0, 32'd0,         32'h0FF0_000F, 0);
    add("err_subi",  INST_TYPE_INT_IMM, FUNCT_SUB,       1, 0, 0, 32'd5, 32'h0000_0013, 1);
    add("err_sbu",   INST_TYPE_STORE,   FUNCT_MEM_BYTEU, 0, 1, 2, 32'd0, 32'h0000_0013, 1);
    add("err_type",  4'hF,              FUNCT_ADD,       1, 1, 1, 32'd0, 32'h0000_0013, 1);
`ifdef IENCODER_RANGE_CHECK_EN
    add("lui_imm1", INST_TYPE_IMM, FUNCT_ADD, 2, 0, 0, 32'h1, 32'h0000_0013, 1);
`else
    add("lui_imm1", INST_TYPE_IMM, FUNCT_ADD, 2, 0, 0, 32'h1, 32'h0000_0137, 0);
`endif

    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_inst", out_inst, 0);
    check("rst_out_err", out_err, 0);
    check("rst_enc_count", enc_count, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b1;

    // Stall the output: three packets fill the stage and both FIFO entries.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(vecs[i]);
    idle();
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_head", out_inst, 32'h0050_0093);
    @(negedge clk);
    out_ready = 1'b1;
    drain();
    check("bp_enc_count", enc_count, 3);
    check("bp_in_ready_after", in_ready, 1);

    // One packet at a time: word must be visible one cycle after acceptance.
    foreach (vecs[i]) begin
      check({"model_", vecs[i].name},
            model(vecs[i].t, vecs[i].f, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm),
            {vecs[i].err, vecs[i].inst});
      send(vecs[i]);
      idle();
      check({"lat_", vecs[i].name}, out_valid, 1);
      check({"inst_", vecs[i].name}, out_inst, vecs[i].inst);
      check({"err_", vecs[i].name}, out_err, vecs[i].err);
    end
    drain();

    // Back-to-back stream at full rate.
    foreach (vecs[i]) send(vecs[i]);
    idle();
    drain();
    check("stream_enc_count", enc_count, 16'(3 + 2 * vecs.size()));

    // Reset while draining discards everything buffered.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(vecs[i + 3]);
    idle();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_enc_count", enc_count, 0);
    check("mid_rst_out_inst", out_inst, 0);
    exp_q.delete();
    model_cnt = '0;
    @(negedge clk);
    rst = 1'b1;
    #4;
    check("post_rst_out_valid", out_valid, 0);

    send(vecs[0]);
    idle();
    check("post_rst_inst", out_inst, 32'h0050_0093);
    drain();
    check("post_rst_enc_count", enc_count, 1);
    check("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
